// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux
//   Round-robin arbiter plus master-to-slave multiplexer for the shared system
//   bus. Grants are registered. The winner's address, strobe, direction and
//   write data are steered combinationally onto the slave side. An owner that
//   has held the bus for MAX_HOLD cycles is preempted when others are waiting.
//   Preemption only happens while the owner has no access in flight, that is,
//   while its strobe is high.
//
// Ports
//   clk        system clock, rising edge
//   reset_     asynchronous active-low reset
//   m_req_     per-master request (active-low)
//   m_addr     packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_as_      per-master address strobe (active-low)
//   m_rw       per-master direction, 1 = read
//   m_wr_data  packed master write data, master i at [i*DATA_W +: DATA_W]
//   m_grnt_    per-master grant (active-low, one-cold or all-high)
//   s_addr     selected address (0 when idle)
//   s_as_      selected strobe (1 when idle)
//   s_rw       selected direction (1 when idle)
//   s_wr_data  selected write data (0 when idle)
//   owner      index of the current or most recent owner
//   bus_busy   high while any grant is asserted
module bus_arbiter_mux #(
  parameter int NUM_M    = 4,
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16,
  localparam int IDW     = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic [NUM_M-1:0]         m_req_,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M-1:0]         m_as_,
  input  logic [NUM_M-1:0]         m_rw,
  input  logic [NUM_M*DATA_W-1:0]  m_wr_data,
  output logic [NUM_M-1:0]         m_grnt_,
  output logic [ADDR_W-1:0]        s_addr,
  output logic                     s_as_,
  output logic                     s_rw,
  output logic [DATA_W-1:0]        s_wr_data,
  output logic [IDW-1:0]           owner,
  output logic                     bus_busy
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_q,  last_d;
  logic [HW-1:0]    hold_q,  hold_d;

  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] others;
  logic [NUM_M-1:0] cand;
  logic [IDW-1:0]   win;
  logic             preempt;

  // Returns the first set bit of req searching upward from base+1 with wrap.
  // The loop runs from the farthest slot to the nearest so the nearest
  // requester is the one left in pick. Returns base when req is empty; the
  // callers check for that case themselves.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_M-1:0] r,
                                             input logic [IDW-1:0]   base);
    logic [IDW-1:0] pick;
    int             idx;
    pick = base;
    for (int k = NUM_M; k >= 1; k--) begin
      idx = (int'(base) + k) % NUM_M;
      if (r[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  assign req    = ~m_req_;
  // While OWNED, grant_q is the owner's one-hot, so it masks the owner out.
  assign others = req & ~grant_q;
  assign cand   = (state_q == IDLE) ? req : others;
  assign win    = rr_pick(cand, last_q);

  // The owner's strobe gates preemption, so a cycle in flight is never cut.
  assign preempt = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|others) &&
                   m_as_[owner_q];

  // State register
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDW'(NUM_M - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic take;
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) take = 1'b1;
      end
      OWNED: begin
        if (!req[owner_q]) begin
          // Release: hand over directly, or fall back to IDLE.
          if (|others) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (preempt) begin
          take = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (take) begin
      state_d = OWNED;
      grant_d = {{(NUM_M-1){1'b0}}, 1'b1} << win;
      owner_d = win;
      last_d  = win;
      hold_d  = '0;
    end
  end

  // Output logic: slave-side mux driven from the registered grant
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (state_q == OWNED) begin
      s_addr    = m_addr[int'(owner_q)*ADDR_W +: ADDR_W];
      s_as_     = m_as_[owner_q];
      s_rw      = m_rw[owner_q];
      s_wr_data = m_wr_data[int'(owner_q)*DATA_W +: DATA_W];
    end
  end

  assign m_grnt_  = ~grant_q;
  assign owner    = owner_q;
  assign bus_busy = ~&m_grnt_;

endmodule
